fwd_mux_reg: RTL and testbench

Parametrised N-source operand-forwarding selector with a registered output, used at the ID/EX boundary to choose each ALU operand among the register file, the EX/MEM/WB forwarding paths and the immediate. It generalises the fixed five-input combinational select to NSRC inputs of WIDTH bits. It adds a pipeline register with stall (enable), flush (bubble insertion), a valid bit, and sticky select-error reporting with a saturating error counter.

---
 rtl/fwd_pkg.sv | 16 +
 rtl/mux_n.sv | 19 +
 rtl/fwd_mux_reg.sv | 89 ++++++++
 tb/tb_fwd_mux_reg.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared constants and types for the ID/EX operand-forwarding selector.
package fwd_pkg;

  localparam int NSRC_DEF  = 5;
  localparam int WIDTH_DEF = 32;
  localparam int SELW_DEF  = $clog2(NSRC_DEF);

  localparam int SRC_RF  = 0;
  localparam int SRC_EX  = 1;
  localparam int SRC_MEM = 2;
  localparam int SRC_WB  = 3;
  localparam int SRC_IMM = 4;

  typedef logic [SELW_DEF-1:0] sel_t;

endpackage

// File: rtl/mux_n.sv
// N-way binary-select mux; any select beyond the last source picks the last source.
module mux_n #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 5,
  parameter int SELW  = $clog2(NSRC)
) (
  input  logic [NSRC*WIDTH-1:0] d,
  input  logic [SELW-1:0]       s,
  output logic [WIDTH-1:0]      y
);

  always_comb begin
    y = d[(NSRC-1)*WIDTH +: WIDTH];
    for (int i = 0; i < NSRC - 1; i++) begin
      if (s == SELW'(i)) y = d[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/fwd_mux_reg.sv
// Registered N-source forwarding selector with stall, flush, valid and
// sticky out-of-range select reporting with a saturating counter.
module fwd_mux_reg
  import fwd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NSRC  = NSRC_DEF,
  parameter int SELW  = $clog2(NSRC),
  parameter int CNTW  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [NSRC*WIDTH-1:0] d,
  input  logic [SELW-1:0]       s,
  input  logic                  clear_err,
  output logic [WIDTH-1:0]      y,
  output logic                  y_valid,
  output logic                  sel_err,
  output logic [CNTW-1:0]       err_cnt
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [WIDTH-1:0] sel_p0;
  logic             oor_p0;
  logic             err_p0;

  logic [WIDTH-1:0] y_p1;
  logic             vld_p1;
  logic             sel_err_p1;
  logic [CNTW-1:0]  err_cnt_p1;

  mux_n #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SELW  (SELW)
  ) u_mux (
    .d (d),
    .s (s),
    .y (sel_p0)
  );

  // A full power-of-two select space has no out-of-range codes.
  generate
    if (NSRC == (1 << SELW)) begin : g_pow2
      assign oor_p0 = 1'b0;
    end else begin : g_npow2
      assign oor_p0 = (s > SELW'(NSRC - 1));
    end
  endgenerate

  assign err_p0 = en & ~flush & in_valid & oor_p0;

  // ---- stage p0 -> p1 ----
  always_ff @(posedge clk) begin
    if (reset) begin
      y_p1       <= '0;
      vld_p1     <= 1'b0;
      sel_err_p1 <= 1'b0;
      err_cnt_p1 <= '0;
    end else begin
      if (flush) begin
        y_p1   <= '0;
        vld_p1 <= 1'b0;
      end else if (en) begin
        y_p1   <= sel_p0;
        vld_p1 <= in_valid;
      end
      if (clear_err) begin
        sel_err_p1 <= 1'b0;
        err_cnt_p1 <= '0;
      end else if (err_p0) begin
        sel_err_p1 <= 1'b1;
        err_cnt_p1 <= sat_inc(err_cnt_p1);
      end
    end
  end

  assign y       = y_p1;
  assign y_valid = vld_p1;
  assign sel_err = sel_err_p1;
  assign err_cnt = err_cnt_p1;

endmodule

// File: tb/tb_fwd_mux_reg.sv
// Directed and table-driven bench for fwd_mux_reg in three configurations.
module tb_fwd_mux_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Config A: NSRC=5, WIDTH=32, CNTW=8
  logic         rst_a = 1'b1, en_a = 1'b0, fl_a = 1'b0, v_a = 1'b0, clr_a = 1'b0;
  logic [159:0] d_a = '0;
  logic [2:0]   s_a = 3'd0;
  logic [31:0]  y_a;
  logic         yv_a, se_a;
  logic [7:0]   cnt_a;

  // Config B: NSRC=5, WIDTH=32, CNTW=2
  logic         rst_b = 1'b1, en_b = 1'b0, fl_b = 1'b0, v_b = 1'b0, clr_b = 1'b0;
  logic [159:0] d_b = '0;
  logic [2:0]   s_b = 3'd0;
  logic [31:0]  y_b;
  logic         yv_b, se_b;
  logic [1:0]   cnt_b;

  // Config C: NSRC=4, WIDTH=8, CNTW=8
  logic         rst_c = 1'b1, en_c = 1'b0, fl_c = 1'b0, v_c = 1'b0, clr_c = 1'b0;
  logic [31:0]  d_c = '0;
  logic [1:0]   s_c = 2'd0;
  logic [7:0]   y_c;
  logic         yv_c, se_c;
  logic [7:0]   cnt_c;

  fwd_mux_reg #(.WIDTH(32), .NSRC(5), .CNTW(8)) dut_a (
    .clk(clk), .reset(rst_a), .en(en_a), .flush(fl_a), .in_valid(v_a),
    .d(d_a), .s(s_a), .clear_err(clr_a),
    .y(y_a), .y_valid(yv_a), .sel_err(se_a), .err_cnt(cnt_a));

  fwd_mux_reg #(.WIDTH(32), .NSRC(5), .CNTW(2)) dut_b (
    .clk(clk), .reset(rst_b), .en(en_b), .flush(fl_b), .in_valid(v_b),
    .d(d_b), .s(s_b), .clear_err(clr_b),
    .y(y_b), .y_valid(yv_b), .sel_err(se_b), .err_cnt(cnt_b));

  fwd_mux_reg #(.WIDTH(8), .NSRC(4), .CNTW(8)) dut_c (
    .clk(clk), .reset(rst_c), .en(en_c), .flush(fl_c), .in_valid(v_c),
    .d(d_c), .s(s_c), .clear_err(clr_c),
    .y(y_c), .y_valid(yv_c), .sel_err(se_c), .err_cnt(cnt_c));

  typedef struct {
    logic        rst, en, fl, v, clr;
    logic [2:0]  s;
    logic [31:0] ey;
    logic        ev, ee;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s [%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] my;
  logic       mv;

  initial begin
    // Reset with random sources and s=1
    for (int i = 0; i < 5; i++) d_a[i*32 +: 32] = $urandom;
    s_a = 3'd1; en_a = 1'b1; v_a = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_y", k, y_a, 32'h0);
      chk("rst_vld", k, {31'h0, yv_a}, 32'h0);
      chk("rst_err", k, {31'h0, se_a}, 32'h0);
      chk("rst_cnt", k, {24'h0, cnt_a}, 32'h0);
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    d_a[32 +: 32] = 32'hDEADBEEF;
    step();
    chk("rel_y", 0, y_a, 32'hDEADBEEF);
    chk("rel_vld", 0, {31'h0, yv_a}, 32'h1);

    for (int i = 0; i < 5; i++) d_a[i*32 +: 32] = 32'(i + 100);

    //            rst  en   fl   v    clr  s     ey       ev   ee   ec
    tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,3'd0,32'd100,1'b1,1'b0,8'd0});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,3'd1,32'd101,1'b1,1'b0,8'd0});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,3'd2,32'd102,1'b1,1'b0,8'd0});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,3'd3,32'd103,1'b1,1'b0,8'd0});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,3'd4,32'd104,1'b1,1'b0,8'd0});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,3'd7,32'd104,1'b1,1'b1,8'd1});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,3'd2,32'd102,1'b1,1'b1,8'd1});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,3'd0,32'd102,1'b1,1'b1,8'd1});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,3'd7,32'd102,1'b1,1'b1,8'd1});
    tbl.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,3'd1,32'd0,  1'b0,1'b1,8'd1});
    tbl.push_back('{1'b0,1'b1,1'b1,1'b1,1'b0,3'd6,32'd0,  1'b0,1'b1,8'd1});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,3'd3,32'd103,1'b1,1'b1,8'd1});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,3'd5,32'd104,1'b0,1'b1,8'd1});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,3'd6,32'd104,1'b1,1'b1,8'd2});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1,3'd0,32'd100,1'b1,1'b0,8'd0});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,3'd5,32'd104,1'b1,1'b1,8'd1});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,3'd7,32'd104,1'b1,1'b1,8'd2});
    tbl.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0,3'd7,32'd0,  1'b0,1'b0,8'd0});
    tbl.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,3'd1,32'd101,1'b1,1'b0,8'd0});
    tbl.push_back('{1'b1,1'b1,1'b1,1'b1,1'b0,3'd7,32'd0,  1'b0,1'b0,8'd0});

    foreach (tbl[i]) begin
      rst_a = tbl[i].rst; en_a = tbl[i].en; fl_a = tbl[i].fl;
      v_a = tbl[i].v; clr_a = tbl[i].clr; s_a = tbl[i].s;
      step();
      chk("tbl_y", i, y_a, tbl[i].ey);
      chk("tbl_vld", i, {31'h0, yv_a}, {31'h0, tbl[i].ev});
      chk("tbl_err", i, {31'h0, se_a}, {31'h0, tbl[i].ee});
      chk("tbl_cnt", i, {24'h0, cnt_a}, {24'h0, tbl[i].ec});
    end
    rst_a = 1'b0;

    // Saturation with a 2-bit counter
    for (int i = 0; i < 5; i++) d_b[i*32 +: 32] = 32'(i + 200);
    en_b = 1'b1; v_b = 1'b1; s_b = 3'd7;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("sat_cnt", k, {30'h0, cnt_b}, (k < 3) ? 32'(k) : 32'd3);
      chk("sat_err", k, {31'h0, se_b}, 32'h1);
      chk("sat_y", k, y_b, 32'd204);
    end
    clr_b = 1'b1;
    step();
    chk("clr_cnt", 0, {30'h0, cnt_b}, 32'h0);
    chk("clr_err", 0, {31'h0, se_b}, 32'h0);
    clr_b = 1'b0;

    // Power-of-two config against a reference model
    my = 8'h0; mv = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      d_c  = $urandom;
      s_c  = 2'($urandom_range(0, 3));
      en_c = ($urandom_range(0, 3) != 0);
      fl_c = ($urandom_range(0, 7) == 0);
      v_c  = $urandom_range(0, 1) == 1;
      if (fl_c) begin
        my = 8'h0; mv = 1'b0;
      end else if (en_c) begin
        my = d_c[s_c*8 +: 8]; mv = v_c;
      end
      step();
      chk("p2_y", k, {24'h0, y_c}, {24'h0, my});
      chk("p2_vld", k, {31'h0, yv_c}, {31'h0, mv});
      if (k % 100 == 99) begin
        chk("p2_err", k, {31'h0, se_c}, 32'h0);
        chk("p2_cnt", k, {24'h0, cnt_c}, 32'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
